// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : param_updown_counter
// Description : Loadable up/down counter with programmable limit, wrap or
//               saturate terminal behaviour, TC pulse, sticky OVF and RCO.
// Revision    : 1.0 - initial release
// ============================================================================
module param_updown_counter #(
    parameter int WIDTH = 8,
    parameter int SAT   = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] IN,
    input  logic [WIDTH-1:0] LIM,
    output logic [WIDTH-1:0] OUT,
    output logic             RCO,
    output logic             TC,
    output logic             OVF
);

    localparam logic [1:0]       c_mode_clear = 2'b00;
    localparam logic [1:0]       c_mode_down  = 2'b01;
    localparam logic [1:0]       c_mode_load  = 2'b10;
    localparam logic [1:0]       c_mode_up    = 2'b11;
    localparam logic [WIDTH-1:0] c_zero       = '0;
    localparam logic [WIDTH-1:0] c_one        = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q,  tc_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        unique case (S)
            c_mode_clear: begin
                cnt_d = c_zero;
                ovf_d = 1'b0;
            end
            c_mode_load: begin
                cnt_d = (IN <= LIM) ? IN : LIM;
            end
            c_mode_up: begin
                if (EN) begin
                    if (cnt_q >= LIM) begin
                        cnt_d = (SAT != 0) ? LIM : c_zero;
                        tc_d  = 1'b1;
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + c_one;
                    end
                end
            end
            c_mode_down: begin
                if (EN) begin
                    if (cnt_q == c_zero) begin
                        cnt_d = (SAT != 0) ? c_zero : LIM;
                        tc_d  = 1'b1;
                        ovf_d = 1'b1;
                    end else if (cnt_q > LIM) begin
                        // Limit lowered under a running count: snap back without an event
                        cnt_d = LIM;
                    end else begin
                        cnt_d = cnt_q - c_one;
                    end
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= c_zero;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign RCO = EN & (((S == c_mode_up) & (cnt_q >= LIM)) |
                       ((S == c_mode_down) & (cnt_q == c_zero)));
    assign OUT = cnt_q;
    assign TC  = tc_q;
    assign OVF = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_updown_counter
// Description : Scoreboard bench for three counter variants (8-bit wrap,
//               8-bit saturate, 16-bit wrap) driven by shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_updown_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [1:0]  s   = 2'b00;
    logic [15:0] in_d  = '0;
    logic [15:0] lim_d = '0;

    logic [7:0]  out_w8, out_s8;
    logic [15:0] out_w16;
    logic        rco_w8, rco_s8, rco_w16;
    logic        tc_w8, tc_s8, tc_w16;
    logic        ovf_w8, ovf_s8, ovf_w16;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(8), .SAT(0)) u_w8 (
        .CLK(clk), .RST(rst), .EN(en), .S(s), .IN(in_d[7:0]), .LIM(lim_d[7:0]),
        .OUT(out_w8), .RCO(rco_w8), .TC(tc_w8), .OVF(ovf_w8)
    );
    param_updown_counter #(.WIDTH(8), .SAT(1)) u_s8 (
        .CLK(clk), .RST(rst), .EN(en), .S(s), .IN(in_d[7:0]), .LIM(lim_d[7:0]),
        .OUT(out_s8), .RCO(rco_s8), .TC(tc_s8), .OVF(ovf_s8)
    );
    param_updown_counter #(.WIDTH(16), .SAT(0)) u_w16 (
        .CLK(clk), .RST(rst), .EN(en), .S(s), .IN(in_d), .LIM(lim_d),
        .OUT(out_w16), .RCO(rco_w16), .TC(tc_w16), .OVF(ovf_w16)
    );

    typedef struct {
        bit          rco_known;
        logic [2:0]  rco;
        logic [15:0] out [3];
        logic [2:0]  tc;
        logic [2:0]  ovf;
    } exp_t;

    exp_t sb_q[$];
    int checks   = 0;
    int failures = 0;

    // Reference state: plain integers, one slot per variant
    int unsigned m_out [3];
    bit          m_tc  [3];
    bit          m_ovf [3];
    bit          m_known = 1'b0;
    int unsigned widths [3] = '{8, 8, 16};
    bit          sats   [3] = '{1'b0, 1'b1, 1'b0};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge and queue expectations.
    task automatic cycle(input bit r, input bit e, input bit [1:0] sel,
                         input bit [15:0] inv, input bit [15:0] limv);
        exp_t it;
        @(negedge clk);
        rst = r; en = e; s = sel; in_d = inv; lim_d = limv;
        it.rco_known = m_known;
        for (int k = 0; k < 3; k++) begin
            int unsigned mod = 1 << widths[k];
            int unsigned lim = limv % mod;
            int unsigned inp = inv % mod;
            int unsigned o   = m_out[k];
            bit          tc  = 1'b0;
            bit          ov  = m_ovf[k];
            it.rco[k] = e && ((sel == 2'd3 && o >= lim) || (sel == 2'd1 && o == 0));
            if (r) begin
                o = 0; ov = 1'b0;
            end else if (sel == 2'd0) begin
                o = 0; ov = 1'b0;
            end else if (sel == 2'd2) begin
                o = (inp <= lim) ? inp : lim;
            end else if (e && sel == 2'd3) begin
                if (o >= lim) begin o = sats[k] ? lim : 0; tc = 1'b1; ov = 1'b1; end
                else o = o + 1;
            end else if (e && sel == 2'd1) begin
                if (o == 0) begin o = sats[k] ? 0 : lim; tc = 1'b1; ov = 1'b1; end
                else if (o > lim) o = lim;
                else o = o - 1;
            end
            m_out[k] = o; m_tc[k] = tc; m_ovf[k] = ov;
            it.out[k] = 16'(o); it.tc[k] = tc; it.ovf[k] = ov;
        end
        if (r) m_known = 1'b1;
        sb_q.push_back(it);
    endtask

    // Monitor: RCO checked mid-cycle, registered outputs just after the edge
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                if (it.rco_known) begin
                    chk("rco_w8",  {15'd0, rco_w8},  {15'd0, it.rco[0]});
                    chk("rco_s8",  {15'd0, rco_s8},  {15'd0, it.rco[1]});
                    chk("rco_w16", {15'd0, rco_w16}, {15'd0, it.rco[2]});
                end
                @(posedge clk);
                #1;
                chk("out_w8",  {8'd0, out_w8},   it.out[0]);
                chk("out_s8",  {8'd0, out_s8},   it.out[1]);
                chk("out_w16", out_w16,          it.out[2]);
                chk("tc_w8",   {15'd0, tc_w8},   {15'd0, it.tc[0]});
                chk("tc_s8",   {15'd0, tc_s8},   {15'd0, it.tc[1]});
                chk("tc_w16",  {15'd0, tc_w16},  {15'd0, it.tc[2]});
                chk("ovf_w8",  {15'd0, ovf_w8},  {15'd0, it.ovf[0]});
                chk("ovf_s8",  {15'd0, ovf_s8},  {15'd0, it.ovf[1]});
                chk("ovf_w16", {15'd0, ovf_w16}, {15'd0, it.ovf[2]});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin m_out[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; end
        repeat (2) cycle(1, 1, 2'd3, 16'h0000, 16'h00FF);

        // Full 8-bit wrap sweep
        repeat (257) cycle(0, 1, 2'd3, 16'h0000, 16'h00FF);
        // Down-count with LIM=9 through two borrows
        cycle(0, 1, 2'd0, 16'h0000, 16'h0009);
        repeat (22) cycle(0, 1, 2'd1, 16'h0000, 16'h0009);
        // Load then count up into the limit, then clamped load
        cycle(0, 0, 2'd2, 16'h0096, 16'h00C8);
        repeat (60) cycle(0, 1, 2'd3, 16'h0000, 16'h00C8);
        cycle(0, 1, 2'd2, 16'h00FA, 16'h00C8);
        // Enable pause while counting
        cycle(0, 1, 2'd2, 16'h0063, 16'h00C8);
        cycle(0, 1, 2'd3, 16'h0000, 16'h00C8);
        repeat (5) cycle(0, 0, 2'd3, 16'h0000, 16'h00C8);
        repeat (2) cycle(0, 1, 2'd3, 16'h0000, 16'h00C8);
        // Limit lowered under a running count
        cycle(0, 1, 2'd2, 16'h0078, 16'h00FF);
        cycle(0, 1, 2'd1, 16'h0000, 16'h0032);
        cycle(0, 1, 2'd3, 16'h0000, 16'h0032);
        // Reset at terminal with overflow set
        cycle(0, 1, 2'd2, 16'h00FF, 16'h00FF);
        cycle(0, 1, 2'd3, 16'h0000, 16'h00FF);
        cycle(0, 1, 2'd2, 16'h00FF, 16'h00FF);
        cycle(1, 1, 2'd3, 16'h0000, 16'h00FF);
        cycle(0, 1, 2'd3, 16'h0000, 16'h00FF);
        // 16-bit wrap at full range
        cycle(0, 1, 2'd2, 16'hFFFE, 16'hFFFF);
        repeat (3) cycle(0, 1, 2'd3, 16'h0000, 16'hFFFF);
        // LIM=0 constant counter in both directions
        repeat (3) cycle(0, 1, 2'd3, 16'h0000, 16'h0000);
        repeat (3) cycle(0, 1, 2'd1, 16'h0000, 16'h0000);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit        r  = ($urandom_range(0, 99) == 0);
            bit        e  = ($urandom_range(0, 9) != 0);
            bit [1:0]  sl = 2'($urandom_range(0, 3));
            bit [15:0] iv = 16'($urandom);
            bit [15:0] lv;
            if (sl == 2'd0 && $urandom_range(0, 3) != 0) sl = 2'd3;
            case ($urandom_range(0, 3))
                0:       lv = 16'($urandom_range(0, 3));
                1:       lv = 16'($urandom_range(0, 20));
                2:       lv = 16'hFFFF;
                default: lv = 16'($urandom);
            endcase
            cycle(r, e, sl, iv, lv);
        end

        repeat (3) @(posedge clk);
        #5;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and data width in bits (legal range 2..32).
REQ-002 SHALL have parameter SAT, default 0, terminal behaviour: 0 = wrap, 1 = saturate.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port EN  input  1  count enable; gates count-up/count-down only.
REQ-006 SHALL have port S  input  2  mode select: 00 clear, 01 count down, 10 load, 11 count up.
REQ-007 SHALL have port IN  input  WIDTH  parallel load data.
REQ-008 SHALL have port LIM  input  WIDTH  upper count limit (terminal value in up direction; modulus = LIM+1).
REQ-009 SHALL have port OUT  output  WIDTH  registered counter value.
REQ-010 SHALL have port RCO  output  1  combinational ripple-carry/borrow lookahead for cascading.
REQ-011 SHALL have port TC  output  1  registered one-cycle terminal-count event pulse.
REQ-012 SHALL have port OVF  output  1  registered sticky overflow/underflow flag.

Function
REQ-013 S=00 SHALL set OUT<=0 and OVF<=0 on the next edge, regardless of EN; TC<=0.
REQ-014 S=10 SHALL set OUT<=IN if IN<=LIM, else OUT<=LIM (clamp), regardless of EN; TC<=0; OVF held.
REQ-015 S=11, EN=1, OUT<LIM SHALL set OUT<=OUT+1; TC<=0.
REQ-016 S=11, EN=1, OUT>=LIM SHALL set OUT<=0 (SAT=0) or OUT<=LIM (SAT=1), TC<=1, OVF<=1.
REQ-017 S=01, EN=1, 0<OUT<=LIM SHALL set OUT<=OUT-1; TC<=0.
REQ-018 S=01, EN=1, OUT==0 SHALL set OUT<=LIM (SAT=0) or hold 0 (SAT=1), TC<=1, OVF<=1.
REQ-019 S=01, EN=1, OUT>LIM (LIM lowered mid-count) SHALL set OUT<=LIM with TC<=0 and OVF unchanged.
REQ-020 S=01 or S=11 with EN=0 SHALL hold OUT and OVF; TC<=0.
REQ-021 TC SHALL be high for exactly one cycle per terminal event; consecutive terminal events (e.g. LIM=0, or SAT=1 held at terminal) SHALL keep TC high on each such cycle.
REQ-022 RCO SHALL equal EN & ((S==11 & OUT>=LIM) | (S==01 & OUT==0)), combinational, no registered delay.
REQ-023 All comparisons and arithmetic SHALL be unsigned WIDTH-bit; no carry bit beyond WIDTH is stored.
REQ-024 LIM SHALL be sampled each cycle (no internal copy); LIM=0 SHALL give a constant-0 counter (wrap) with TC on every enabled count cycle.
REQ-025 Latency: OUT, TC, OVF change exactly one edge after the qualifying inputs; RCO reflects current inputs and OUT within the same cycle.

Reset
REQ-026 RST=1 at a rising edge SHALL set OUT=0, TC=0, OVF=0, overriding S and EN.
REQ-027 RST SHALL take priority mid-count, mid-load and at terminal; the cycle after RST deasserts SHALL execute S normally from OUT=0.
REQ-028 Before the first reset edge, outputs are undefined; the bench SHALL apply RST for at least 2 cycles.

Verification (WIDTH=8 unless stated)
REQ-029 SAT=0, LIM=255, S=11, EN=1 from 0 for 257 edges -> OUT 0..255, 0, 1; TC and OVF rise after the 255->0 edge; RCO high while OUT=255.
REQ-030 SAT=0, LIM=9, S=01, EN=1 from 0 -> OUT 9,8,...,0,9; TC pulse on each 0->9 edge; RCO high only at OUT=0.
REQ-031 SAT=1, LIM=200, load IN=0x96 then S=11 -> OUT 150..200 then holds 200 with TC high every enabled cycle; load IN=0xFA -> OUT=200 (clamped).
REQ-032 Counting up at OUT=100, set EN=0 for 5 cycles -> OUT holds 100, TC=0, RCO=0; EN=1 resumes at 101.
REQ-033 OUT=120, LIM changed to 50, S=01 -> OUT=50 next edge, TC=0; S=11 at OUT=50 -> OUT=0, TC=1.
REQ-034 RST=1 asserted with S=11 at OUT=255 and OVF=1 -> next edge OUT=0, TC=0, OVF=0; WIDTH=16, LIM=65535 wrap check -> 65535->0 with TC=1.
